// File: rtl/rv_wb_master_if.sv
// Signal bundle between the core's fetch/data requesters, rv_wb_master and the Wishbone interconnect.
// The master modport is the rv_wb_master side; the slave modport is the requester/interconnect side.
interface rv_wb_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Handshake: a requester raises *_req with its address/data and holds them unchanged until its own
  // ack/err pulses for one cycle; it drops req in that same cycle or it is served again. Wishbone side
  // is classic: cyc/stb held until the slave answers with ack or err.
  logic                      i_if_req;
  logic [ADDR_WIDTH-1:0]     i_if_addr;
  logic                      o_if_ack;
  logic                      o_if_err;
  logic                      i_d_req;
  logic [ADDR_WIDTH-1:0]     i_d_addr;
  logic [DATA_WIDTH-1:0]     i_d_wdata;
  logic                      i_d_we;
  logic [DATA_WIDTH/8-1:0]   i_d_sel;
  logic                      o_d_ack;
  logic                      o_d_err;
  logic [DATA_WIDTH-1:0]     o_rdata;
  logic [ADDR_WIDTH-1:0]     o_wb_adr;
  logic [DATA_WIDTH-1:0]     o_wb_dat;
  logic                      o_wb_we;
  logic [DATA_WIDTH/8-1:0]   o_wb_sel;
  logic                      o_wb_stb;
  logic                      o_wb_cyc;
  logic [DATA_WIDTH-1:0]     i_wb_dat;
  logic                      i_wb_ack;
  logic                      i_wb_err;

  modport master (
    input  i_if_req, i_if_addr, i_d_req, i_d_addr, i_d_wdata, i_d_we, i_d_sel,
    input  i_wb_dat, i_wb_ack, i_wb_err,
    output o_if_ack, o_if_err, o_d_ack, o_d_err, o_rdata,
    output o_wb_adr, o_wb_dat, o_wb_we, o_wb_sel, o_wb_stb, o_wb_cyc
  );

  modport slave (
    output i_if_req, i_if_addr, i_d_req, i_d_addr, i_d_wdata, i_d_we, i_d_sel,
    output i_wb_dat, i_wb_ack, i_wb_err,
    input  o_if_ack, o_if_err, o_d_ack, o_d_err, o_rdata,
    input  o_wb_adr, o_wb_dat, o_wb_we, o_wb_sel, o_wb_stb, o_wb_cyc
  );
endinterface

// File: rtl/rv_wb_master.sv
// Wishbone classic master shared by instruction fetch and data channels (data has fixed priority).
// Optional bus timeout: define RV_WB_TIMEOUT_EN to force an error after TIMEOUT_CYCLES in BUS.
module rv_wb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  rv_wb_master_if.master       bus,
  output logic [1:0]           o_state_dbg
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]            state_q,  state_d;
  logic                  owner_d_q, owner_d_d;
  logic                  cyc_q,    cyc_d;
  logic [ADDR_WIDTH-1:0] adr_q,    adr_d;
  logic [DATA_WIDTH-1:0] dat_q,    dat_d;
  logic                  we_q,     we_d;
  logic [SEL_WIDTH-1:0]  sel_q,    sel_d;
  logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
  logic                  if_ack_q, if_ack_d;
  logic                  if_err_q, if_err_d;
  logic                  d_ack_q,  d_ack_d;
  logic                  d_err_q,  d_err_d;
  logic                  timeout_hit;
  logic                  term_err;

`ifdef RV_WB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] timer_q, timer_d;

  // Timer holds zero outside BUS, so it is already cleared on BUS entry.
  assign timeout_hit = (state_q == ST_BUS) && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
  assign timer_d     = (state_q == ST_BUS) ? timer_q + TMR_W'(1) : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) timer_q <= '0;
    else         timer_q <= timer_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d_d = owner_d_q;
    cyc_d     = cyc_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    we_d      = we_q;
    sel_d     = sel_q;
    rdata_d   = rdata_q;
    if_ack_d  = 1'b0;
    if_err_d  = 1'b0;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    term_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_d_req) begin
          owner_d_d = 1'b1;
          cyc_d     = 1'b1;
          adr_d     = bus.i_d_addr;
          dat_d     = bus.i_d_wdata;
          we_d      = bus.i_d_we;
          sel_d     = bus.i_d_sel;
          state_d   = ST_BUS;
        end else if (bus.i_if_req) begin
          owner_d_d = 1'b0;
          cyc_d     = 1'b1;
          adr_d     = bus.i_if_addr;
          dat_d     = '0;
          we_d      = 1'b0;
          sel_d     = '1;
          state_d   = ST_BUS;
        end
      end
      ST_BUS: begin
        // ERR beats ACK; a timeout only counts when the slave is silent.
        if (bus.i_wb_ack || bus.i_wb_err || timeout_hit) begin
          term_err = bus.i_wb_err || (timeout_hit && !bus.i_wb_ack);
          cyc_d    = 1'b0;
          state_d  = ST_RESP;
          if_ack_d = !owner_d_q && !term_err;
          if_err_d = !owner_d_q &&  term_err;
          d_ack_d  =  owner_d_q && !term_err;
          d_err_d  =  owner_d_q &&  term_err;
          if (!term_err && !we_q) rdata_d = bus.i_wb_dat;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      owner_d_q <= 1'b0;
      cyc_q     <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      rdata_q   <= '0;
      if_ack_q  <= 1'b0;
      if_err_q  <= 1'b0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_d_q <= owner_d_d;
      cyc_q     <= cyc_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
      if_ack_q  <= if_ack_d;
      if_err_q  <= if_err_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
    end
  end

  assign bus.o_wb_cyc = cyc_q;
  assign bus.o_wb_stb = cyc_q;
  assign bus.o_wb_adr = adr_q;
  assign bus.o_wb_dat = dat_q;
  assign bus.o_wb_we  = we_q;
  assign bus.o_wb_sel = sel_q;
  assign bus.o_rdata  = rdata_q;
  assign bus.o_if_ack = if_ack_q;
  assign bus.o_if_err = if_err_q;
  assign bus.o_d_ack  = d_ack_q;
  assign bus.o_d_err  = d_err_q;
  assign o_state_dbg  = state_q;
endmodule
